// File: rtl/hdmi_line_fetch_if.sv
// Request/stream link between the line fetcher and the frame store.
// The line fetcher drives requests; the frame store streams pixel words back.
interface hdmi_line_fetch_if #(
  parameter int LINE_W     = 10,
  parameter int DATA_WIDTH = 24
);
  logic                  req_valid;
  logic                  req_ready;
  logic [LINE_W-1:0]     req_line;
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output req_valid, req_line,
    input  req_ready, data_valid, data
  );

  modport slave (
    input  req_valid, req_line,
    output req_ready, data_valid, data
  );
endinterface

// File: rtl/hdmi_line_fetch.sv
// Ping-pong line buffer between the HDMI timing generator and the TMDS encoders.
// Line N+1 is fetched from the frame store while line N is displayed.
module hdmi_line_fetch #(
  parameter int H_ACTIVE   = 1024,
  parameter int V_ACTIVE   = 600,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  active,
  input  logic                  h_sync,
  input  logic                  v_sync,
  input  logic                  h_start,
  input  logic                  v_start,
  hdmi_line_fetch_if.master     bus,
  output logic                  out_active,
  output logic                  out_h_sync,
  output logic                  out_v_sync,
  output logic [DATA_WIDTH-1:0] rgb,
  output logic                  locked,
  output logic                  underrun
);
  localparam int ADDR_W = $clog2(H_ACTIVE);
  localparam int LINE_W = $clog2(V_ACTIVE);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t                state, state_next;
  logic                  run;
  logic                  front;
  logic [ADDR_W-1:0]     wr_addr, rd_addr, rd_addr_now, rd_addr_next;
  logic [LINE_W-1:0]     line_cnt, line_cnt_next, req_line, req_line_next;
  logic                  line_start, swap, rd_sel, wr_en, last_word, req_fire;
  logic                  act_d1, hs_d1, vs_d1;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] mem [2][H_ACTIVE];

  // run holds req_valid low for the whole reset period, including the cycle REQ is entered.
  assign bus.req_valid = run && (state == REQ);
  assign bus.req_line  = req_line;
  assign req_fire      = bus.req_valid && bus.req_ready;

  // Before lock only a v_start with line 0 already buffered counts as a line start.
  assign line_start = locked ? h_start : (v_start && (state == IDLE));
  assign swap       = line_start && (state == IDLE);
  assign rd_sel     = swap ? ~front : front;

  assign rd_addr_now  = h_start ? '0 : rd_addr;
  assign rd_addr_next = (active && (rd_addr_now != ADDR_LAST)) ? rd_addr_now + 1'b1 : rd_addr_now;

  assign wr_en     = (state == DATA) && bus.data_valid;
  assign last_word = wr_en && (wr_addr == ADDR_LAST);

  assign line_cnt_next = v_start ? '0 : ((line_cnt == LINE_LAST) ? '0 : line_cnt + 1'b1);
  assign req_line_next = (line_cnt_next == LINE_LAST) ? '0 : line_cnt_next + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= REQ;
    else          state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (swap)      state_next = REQ;
      REQ:     if (req_fire)  state_next = DATA;
      DATA:    if (last_word) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run      <= 1'b0;
      front    <= 1'b0;
      locked   <= 1'b0;
      underrun <= 1'b0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      line_cnt <= '0;
      req_line <= '0;
    end else begin
      run     <= 1'b1;
      rd_addr <= rd_addr_next;
      if (wr_en) wr_addr <= last_word ? '0 : wr_addr + 1'b1;
      if (line_start) begin
        locked   <= 1'b1;
        line_cnt <= line_cnt_next;
        if (swap) begin
          front    <= ~front;
          req_line <= req_line_next;
        end else begin
          // Fetch still in flight: keep showing the old front buffer.
          underrun <= 1'b1;
        end
      end
    end
  end

  // NOTE: the line buffers have no reset; stale contents are masked by locked and active.
  always_ff @(posedge clk) begin
    if (wr_en) mem[~front][wr_addr] <= bus.data;
    ram_q <= mem[rd_sel][rd_addr_now];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      act_d1     <= 1'b0;
      hs_d1      <= 1'b0;
      vs_d1      <= 1'b0;
      out_active <= 1'b0;
      out_h_sync <= 1'b0;
      out_v_sync <= 1'b0;
      rgb        <= '0;
    end else begin
      act_d1     <= active;
      hs_d1      <= h_sync;
      vs_d1      <= v_sync;
      out_active <= act_d1;
      out_h_sync <= hs_d1;
      out_v_sync <= vs_d1;
      rgb        <= (act_d1 && locked) ? ram_q : '0;
    end
  end
endmodule
